// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control: PC increment, stall, branch/jump redirect
// with a NOP flush window, and a terminal halt state.
`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module pc_fetch_unit #(
    parameter int unsigned MEM_SPACE    = `MEM_SPACE,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 jump_taken,
    input  logic [MEM_SPACE-1:0] jump_target,
    input  logic                 branch_taken,
    input  logic [MEM_SPACE-1:0] branch_target,
    input  logic                 halt,
    output logic [MEM_SPACE-1:0] address,
    output logic [MEM_SPACE-1:0] pc_plus1,
    output logic                 PCctrl,
    output logic                 halted
);

    localparam int unsigned CNT_W     = 3;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [MEM_SPACE-1:0] addr_d;
    logic                 ctrl_d;
    logic                 halted_d;
    logic                 redirect_c;
    logic [MEM_SPACE-1:0] target_c;

    // Branch is the older instruction, so it wins over a same-cycle jump.
    assign redirect_c = branch_taken | jump_taken;
    assign target_c   = branch_taken ? branch_target : jump_target;

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        addr_d   = address;
        ctrl_d   = PCctrl;
        halted_d = halted;
        case (state)
            RUN: begin
                if (redirect_c) begin
                    addr_d  = target_c;
                    ctrl_d  = 1'b1;
                    cnt_d   = FLUSH_LOAD;
                    state_d = FLUSH;
                end else if (halt) begin
                    ctrl_d   = 1'b1;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (stall) begin
                    ctrl_d = 1'b0;
                end else begin
                    addr_d = address + MEM_SPACE'(1);
                    ctrl_d = 1'b0;
                end
            end
            FLUSH: begin
                if (redirect_c) begin
                    addr_d = target_c;
                    ctrl_d = 1'b1;
                    cnt_d  = FLUSH_LOAD;
                end else if (cnt == '0) begin
                    ctrl_d  = 1'b0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            HALT: begin
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            cnt      <= '0;
            address  <= '0;
            pc_plus1 <= MEM_SPACE'(1);
            PCctrl   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            address  <= addr_d;
            pc_plus1 <= addr_d + MEM_SPACE'(1);
            PCctrl   <= ctrl_d;
            halted   <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (flush window 1 and 3) driven in
// lockstep, checked against a reference model scoreboard plus directed values.
module tb_pc_fetch_unit;

    localparam int unsigned MS = 8;

    typedef struct packed {
        logic [MS-1:0] addr;
        logic [MS-1:0] p1;
        logic          ctrl;
        logic          hlt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          stall = 1'b0;
    logic          jump_taken = 1'b0;
    logic [MS-1:0] jump_target = '0;
    logic          branch_taken = 1'b0;
    logic [MS-1:0] branch_target = '0;
    logic          halt = 1'b0;

    logic [MS-1:0] a_address, a_pc_plus1, b_address, b_pc_plus1;
    logic          a_PCctrl, a_halted, b_PCctrl, b_halted;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model state per instance (0: flush 1, 1: flush 3)
    logic [MS-1:0] m_addr[2];
    logic          m_ctrl[2];
    logic          m_hlt[2];
    int            m_st[2];
    int            m_cnt[2];
    int            fc[2];

    always #5 clk = ~clk;

    pc_fetch_unit #(.MEM_SPACE(MS), .FLUSH_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .address(a_address), .pc_plus1(a_pc_plus1),
        .PCctrl(a_PCctrl), .halted(a_halted)
    );

    pc_fetch_unit #(.MEM_SPACE(MS), .FLUSH_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_taken(jump_taken), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .address(b_address), .pc_plus1(b_pc_plus1),
        .PCctrl(b_PCctrl), .halted(b_halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Priority order: reset, halt state, redirect, flush countdown, halt, stall, increment.
    task automatic model_step(input int i);
        if (!rst) begin
            m_addr[i] = '0; m_ctrl[i] = 1'b0; m_hlt[i] = 1'b0; m_st[i] = 0; m_cnt[i] = 0;
        end else if (m_st[i] == 2) begin
            // frozen
        end else if (branch_taken || jump_taken) begin
            m_addr[i] = branch_taken ? branch_target : jump_target;
            m_ctrl[i] = 1'b1;
            m_cnt[i]  = fc[i] - 1;
            m_st[i]   = 1;
        end else if (m_st[i] == 1) begin
            if (m_cnt[i] == 0) begin
                m_ctrl[i] = 1'b0;
                m_st[i]   = 0;
            end else begin
                m_cnt[i] = m_cnt[i] - 1;
            end
        end else if (halt) begin
            m_ctrl[i] = 1'b1; m_hlt[i] = 1'b1; m_st[i] = 2;
        end else if (stall) begin
            m_ctrl[i] = 1'b0;
        end else begin
            m_addr[i] = m_addr[i] + MS'(1);
            m_ctrl[i] = 1'b0;
        end
    endtask

    task automatic compare_q(input string who, inout exp_t q[$], input logic [MS-1:0] addr,
                             input logic [MS-1:0] p1, input logic ctrl, input logic hlt);
        exp_t e;
        if (q.size() == 0) begin
            chk({who, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            chk({who, "_address"}, 32'(addr), 32'(e.addr));
            chk({who, "_pc_plus1"}, 32'(p1), 32'(e.p1));
            chk({who, "_PCctrl"}, 32'(ctrl), 32'(e.ctrl));
            chk({who, "_halted"}, 32'(hlt), 32'(e.hlt));
        end
    endtask

    // Drive one cycle of inputs, predict, clock, then compare #1 after the edge.
    task automatic step(input logic r, input logic st, input logic j, input logic [MS-1:0] jt,
                        input logic b, input logic [MS-1:0] bt, input logic h);
        rst = r; stall = st; jump_taken = j; jump_target = jt;
        branch_taken = b; branch_target = bt; halt = h;
        for (int i = 0; i < 2; i++) model_step(i);
        qa.push_back('{m_addr[0], m_addr[0] + MS'(1), m_ctrl[0], m_hlt[0]});
        qb.push_back('{m_addr[1], m_addr[1] + MS'(1), m_ctrl[1], m_hlt[1]});
        @(posedge clk);
        #1;
        compare_q("a", qa, a_address, a_pc_plus1, a_PCctrl, a_halted);
        compare_q("b", qb, b_address, b_pc_plus1, b_PCctrl, b_halted);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        fc[0] = 1; fc[1] = 3;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = '0; m_ctrl[i] = 1'b0; m_hlt[i] = 1'b0; m_st[i] = 0; m_cnt[i] = 0;
        end

        // Reset for two edges, then free-run increment
        do_reset();
        do_reset();
        chk("rst_address", 32'(a_address), 32'h0);
        chk("rst_pc_plus1", 32'(a_pc_plus1), 32'h1);
        chk("rst_PCctrl", 32'(a_PCctrl), 32'h0);
        chk("rst_halted", 32'(a_halted), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk("seq_address", 32'(a_address), 32'(k));
            chk("seq_pc_plus1", 32'(a_pc_plus1), 32'(k + 1));
            chk("seq_PCctrl", 32'(a_PCctrl), 32'h0);
        end

        // Jump at address 5 to 0x20
        step(1'b1, 1'b0, 1'b1, 8'h20, 1'b0, '0, 1'b0);
        chk("jmp_address", 32'(a_address), 32'h20);
        chk("jmp_PCctrl", 32'(a_PCctrl), 32'h1);
        idle(1);
        chk("jmp_hold_address", 32'(a_address), 32'h20);
        chk("jmp_hold_PCctrl", 32'(a_PCctrl), 32'h0);
        chk("jmp3_PCctrl", 32'(b_PCctrl), 32'h1);
        idle(1);
        chk("jmp_next_address", 32'(a_address), 32'h21);
        idle(2);

        // Branch + jump + stall together: branch wins, stall ignored
        step(1'b1, 1'b1, 1'b1, 8'h20, 1'b1, 8'h40, 1'b0);
        chk("prio_address", 32'(a_address), 32'h40);
        chk("prio_PCctrl", 32'(a_PCctrl), 32'h1);
        chk("prio3_address", 32'(b_address), 32'h40);
        idle(1);
        chk("prio_release_address", 32'(a_address), 32'h40);
        chk("prio_release_PCctrl", 32'(a_PCctrl), 32'h0);
        idle(3);

        // Stall three cycles at the top address, then wrap
        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, '0, 1'b0);
        idle(1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
            chk("stall_address", 32'(a_address), 32'hFF);
            chk("stall_PCctrl", 32'(a_PCctrl), 32'h0);
        end
        idle(1);
        chk("wrap_address", 32'(a_address), 32'h0);
        chk("wrap_pc_plus1", 32'(a_pc_plus1), 32'h1);
        idle(2);

        // Halt at address 9, then toggle stall/jump while frozen
        step(1'b1, 1'b0, 1'b1, 8'h09, 1'b0, '0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            step(1'b1, k[0], k[1], 8'h33, 1'b0, '0, 1'b0);
            chk("halt_address", 32'(a_address), 32'h09);
            chk("halt_PCctrl", 32'(a_PCctrl), 32'h1);
            chk("halt_halted", 32'(a_halted), 32'h1);
        end

        // Halt on the wrong path: branch takes precedence
        do_reset();
        idle(2);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 8'h30, 1'b1);
        chk("wp_address", 32'(a_address), 32'h30);
        chk("wp_halted", 32'(a_halted), 32'h0);
        chk("wp_PCctrl", 32'(a_PCctrl), 32'h1);
        idle(4);

        // Reset mid-flush with the 3-cycle instance's counter at 1
        do_reset();
        step(1'b1, 1'b0, 1'b1, 8'h10, 1'b0, '0, 1'b0);
        idle(1);
        chk("midflush_PCctrl_pre", 32'(b_PCctrl), 32'h1);
        do_reset();
        chk("midflush_address", 32'(b_address), 32'h0);
        chk("midflush_PCctrl", 32'(b_PCctrl), 32'h0);
        chk("midflush_halted", 32'(b_halted), 32'h0);
        idle(1);
        chk("midflush_run_address", 32'(b_address), 32'h1);

        // Reset during halt
        step(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
        chk("halt3_halted", 32'(b_halted), 32'h1);
        idle(2);
        do_reset();
        chk("halt_rst_address", 32'(b_address), 32'h0);
        chk("halt_rst_PCctrl", 32'(b_PCctrl), 32'h0);
        chk("halt_rst_halted", 32'(b_halted), 32'h0);
        idle(1);
        chk("halt_rst_run_address", 32'(b_address), 32'h1);

        // Random traffic checked by the scoreboard only
        for (int k = 0; k < 200; k++) begin
            step(($urandom_range(0, 19) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), MS'($urandom),
                 ($urandom_range(0, 9) == 0), MS'($urandom),
                 ($urandom_range(0, 24) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-control stage that sits directly upstream of the instruction memory. It drives the instruction address and the `PCctrl` squash line every cycle. It sequences PC increment, pipeline stall, and jump/branch redirection with a configurable NOP-bubble window. It also provides a terminal halt state, so the instruction memory emits either `memory[pc]` or a NOP (16'h0000) on each rising edge.

## Interface
- `MEM_SPACE`, default `` `MEM_SPACE `` from define.v: PC/address width; the PC wraps modulo 2**MEM_SPACE.
- `FLUSH_CYCLES`, default 1: number of consecutive fetches squashed after a redirect; legal range 1..7.
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-low reset; sampled only on the rising edge of `clk`.
- `stall`  input  1: hazard unit request to hold the PC.
- `jump_taken`  input  1: decode-stage unconditional jump.
- `jump_target`  input  MEM_SPACE: jump destination.
- `branch_taken`  input  1: execute-stage resolved taken branch.
- `branch_target`  input  MEM_SPACE: branch destination.
- `halt`  input  1: decode-stage halt instruction detected.
- `address`  output  MEM_SPACE: registered PC driven to instruction memory.
- `pc_plus1`  output  MEM_SPACE: registered `address`+1 (wrapped), for link/branch base.
- `PCctrl`  output  1: registered; 1 = instruction memory must output NOP this fetch.
- `halted`  output  1: registered; 1 while in HALT.

## Operation
- States: RUN, FLUSH, HALT. Flush counter is 3 bits wide.
- Reset (`rst`==0 at an edge):
  - `address`=0, `pc_plus1`=1, `PCctrl`=0, `halted`=0, state=RUN, counter=0.
  - Reset overrides every other input in every state, including mid-FLUSH and HALT.
- Redirect priority:
  - `branch_taken` beats `jump_taken`, because the branch is the older instruction.
  - Any redirect beats `stall`.
  - `halt` has the lowest priority; it is ignored in a cycle with a redirect, because the halting instruction is on the wrong path.
- RUN:
  - Redirect: `address`<=target, `PCctrl`<=1, counter<=FLUSH_CYCLES-1, go to FLUSH.
  - Else `halt`: `address` held, `PCctrl`<=1, `halted`<=1, go to HALT.
  - Else `stall`: `address` held, `PCctrl`<=0.
  - Else: `address`<=`address`+1, `PCctrl`<=0.
- FLUSH:
  - The PC holds the target and does not increment.
  - If counter==0: `PCctrl`<=0, go to RUN. The target is fetched next edge, and increment resumes the cycle after that.
  - Else: counter<=counter-1, `PCctrl` stays 1.
  - A new redirect in FLUSH reloads the target and counter (restarts the flush); the younger redirect is discarded.
  - `stall` and `halt` are ignored in FLUSH.
- HALT: all outputs frozen (`PCctrl`=1, `halted`=1); leaves only on reset.
- Arithmetic: `pc_plus1` is always `address`+1 truncated to MEM_SPACE bits, updated in the same edge as `address`.
  - Example: 2**MEM_SPACE-1 increments to 0, and `pc_plus1` is then 1.

## Timing
- Every output is registered. No combinational path from any input to any output.
- Fetch latency: `address`=A at edge n gives instruction data at edge n+1.
- Redirect sampled at edge n gives the following:
  - Edge n+1..n+FLUSH_CYCLES: the instruction memory emits NOP.
  - Edge n+FLUSH_CYCLES+1: it emits `memory[target]`.
  - The wrong-path word latched at edge n is killed by the IF/ID flush, not by this block.
- A single stall cycle repeats one fetch of the same address. Stall held for k cycles repeats it k times.
- Simultaneous `branch_taken` and `jump_taken`: `branch_target` is loaded, the jump is dropped, and the flush length is unchanged.

## Test plan
- Reset and sequencing: `rst`=0 for 2 edges, then 1 with no other inputs.
  - Required: `address` goes 0,1,2,3… and `pc_plus1` goes 1,2,3,4…
  - Required: `PCctrl`=0 throughout.
- Jump: at `address`=5, assert `jump_taken` for 1 cycle with `jump_target`=0x20 and FLUSH_CYCLES=1.
  - Required: next edge `address`=0x20 and `PCctrl`=1.
  - Required: following edge `PCctrl`=0 and `address`=0x20; next edge `address`=0x21.
- Priority: assert `branch_taken` (target 0x40), `jump_taken` (target 0x20) and `stall` together.
  - Required: `address`=0x40, state FLUSH, and the stall is ignored.
- Stall and wrap: hold `stall` 3 cycles at `address`=2**MEM_SPACE-1, then release.
  - Required: `address` held for 3 edges, then becomes 0, with `pc_plus1`=1.
- Halt, and halt on the wrong path:
  - `halt` at `address`=9: required `halted`=1, `PCctrl`=1, and `address`=9 frozen for 10+ cycles, despite `stall` or `jump_taken` toggling.
  - `halt` together with `branch_taken`: required no halt, and a branch redirect taken instead.
- Reset mid-operation: with FLUSH_CYCLES=3, assert `rst`=0 during FLUSH with the counter at 1, and separately during HALT.
  - Required: next edge `address`=0, `PCctrl`=0, `halted`=0, state RUN.
